// File: rtl/rx_pkg.sv
// Shared types and constants for the parametrised UART receive path.
// RX_ERR_STATUS_EN adds per-entry error status to the receive FIFO.
package rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_e;

  // Status carried next to the data word of each FIFO entry.
  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_status_t;

`ifdef RX_ERR_STATUS_EN
  localparam int STATUS_W = $bits(rx_status_t);
`else
  localparam int STATUS_W = 0;
`endif

  // xor_all is the XOR of every data bit and the received parity bit.
  function automatic logic parity_fail(input logic xor_all, input parity_mode_e mode);
    return (mode == PAR_ODD) ? ~xor_all : xor_all;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with registered read port and wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rx_unit_param.sv
// UART receiver: 2-FF synchroniser, oversampling frame FSM, error flags, receive FIFO.
// Define RX_ERR_STATUS_EN to also store errored frames with their status bits.
module rx_unit_param
  import rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 2,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          rx,
  input  logic                          ren,
  output logic [DATA_BITS-1:0]          read_data,
  output logic                          rx_done,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          rx_full,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef RX_ERR_STATUS_EN
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
`endif
  output logic [2:0]                    state_dbg
);

  localparam int                TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]     HALF_T    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]     FULL_T    = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]        LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);
  localparam parity_mode_e      PMODE     = parity_mode_e'(PARITY_MODE[1:0]);
  localparam int                EW        = DATA_BITS + STATUS_W;

  logic                 rx_s1, rx_s2;
  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 bit_edge;
  logic                 frame_end;
  logic                 fe_now;
  logic                 push_req;
  logic                 pop_acc;
  logic [EW-1:0]        fifo_wr;
  logic [EW-1:0]        fifo_rd;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // Bit-centre sample point once the start bit has been qualified.
  assign bit_edge  = sample_tick && (tick_cnt == FULL_T);
  assign frame_end = (state == ST_STOP) && bit_edge && (stop_cnt == LAST_STOP);
  assign fe_now    = stop_bad || !rx_s2;
  assign pop_acc   = ren && !rx_empty;

`ifdef RX_ERR_STATUS_EN
  assign push_req = frame_end;
  assign fifo_wr  = {par_bad, fe_now, shift_reg};
`else
  assign push_req = frame_end && !fe_now && !par_bad;
  assign fifo_wr  = shift_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done    <= frame_end;
      parity_err <= frame_end && par_bad;
      frame_err  <= frame_end && fe_now;
      case (state)
        ST_IDLE: begin
          if (!rx_s2) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (sample_tick) begin
            if (tick_cnt == HALF_T) begin
              tick_cnt <= '0;
              state    <= rx_s2 ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (sample_tick) begin
            if (tick_cnt == FULL_T) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s2, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (sample_tick) begin
            if (tick_cnt == FULL_T) begin
              tick_cnt <= '0;
              par_bad  <= parity_fail((^shift_reg) ^ rx_s2, PMODE);
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (sample_tick) begin
            if (tick_cnt == FULL_T) begin
              tick_cnt <= '0;
              stop_cnt <= stop_cnt + 1'b1;
              if (!rx_s2) stop_bad <= 1'b1;
              // A line still held low at the last stop bit is a break condition.
              if (stop_cnt == LAST_STOP) state <= (fe_now && !rx_s2) ? ST_BREAK : ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky until the host drains an entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_err <= 1'b0;
    end else if (pop_acc) begin
      overrun_err <= 1'b0;
    end else if (push_req && rx_full) begin
      overrun_err <= 1'b1;
    end
  end

  rx_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_req),
    .wr_data (fifo_wr),
    .rd_en   (ren),
    .rd_data (fifo_rd),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (fifo_count)
  );

  assign read_data = fifo_rd[DATA_BITS-1:0];
`ifdef RX_ERR_STATUS_EN
  assign {rd_parity_err, rd_frame_err} = fifo_rd[EW-1 -: 2];
`endif

endmodule

// File: tb/tb_rx_unit_param.sv
// Bench for rx_unit_param (8E1, 16x oversample, depth 8): directed cases then
// randomized frames checked against a queue-based model of the receive path.
`timescale 1ns/1ps
module tb_rx_unit_param;
  import rx_pkg::*;

  localparam int DEPTH = 8;
  localparam int OS    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx;
  logic       ren;
  logic [7:0] read_data;
  logic       rx_done, parity_err, frame_err, overrun_err, rx_full, rx_empty;
  logic [3:0] fifo_count;
`ifdef RX_ERR_STATUS_EN
  logic       rd_parity_err, rd_frame_err;
`endif
  logic [2:0] state_dbg;

  rx_unit_param #(
    .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx), .ren(ren),
    .read_data(read_data), .rx_done(rx_done), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .rx_full(rx_full),
    .rx_empty(rx_empty), .fifo_count(fifo_count),
`ifdef RX_ERR_STATUS_EN
    .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset / tick generation
  always #5 clk = ~clk;

  int tick_div = 1;
  int tick_ph  = 0;
  always @(negedge clk) begin
    tick_ph     = (tick_ph + 1) % tick_div;
    sample_tick = (tick_ph == 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [1:0] done_q[$];
  int         cnt_q[$];
  int         stray    = 0;
  logic       model_ovr = 1'b0;
  logic [7:0] last_rd   = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(negedge clk) begin
    if (rx_done) begin
      done_q.push_back({parity_err, frame_err});
      cnt_q.push_back(int'(fifo_count));
    end else if (parity_err || frame_err) begin
      stray++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (OS * tick_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ bad_par);
    drive_bit(stop_val);
  endtask

  task automatic idle_gap();
    rx = 1'b1;
    repeat (OS * tick_div + 8) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"},   32'(fifo_count),  32'(exp_q.size()));
    check({tag, "_full"},    32'(rx_full),     32'(exp_q.size() == DEPTH));
    check({tag, "_empty"},   32'(rx_empty),    32'(exp_q.size() == 0));
    check({tag, "_overrun"}, 32'(overrun_err), 32'(model_ovr));
  endtask

  task automatic check_frame(input logic [7:0] d, input bit bad_par, input logic stop_val);
    logic [1:0] rec;
    int         c;
    bit         exp_fe;
    exp_fe = (stop_val == 1'b0);
    if (!bad_par && !exp_fe) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else model_ovr = 1'b1;
    end
    check("done_pulses", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      rec = done_q.pop_front();
      c   = cnt_q.pop_front();
      check("err_pulses", 32'(rec), 32'({bad_par, exp_fe}));
      check("count_at_done", 32'(c), 32'(exp_q.size()));
    end
    done_q.delete();
    cnt_q.delete();
    check_status("frame");
  endtask

  task automatic frame_and_check(input logic [7:0] d, input bit bad_par, input logic stop_val);
    send_frame(d, bad_par, stop_val);
    idle_gap();
    check_frame(d, bad_par, stop_val);
  endtask

  task automatic do_read();
    bit was_empty;
    was_empty = (exp_q.size() == 0);
    ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    if (!was_empty) begin
      last_rd   = exp_q.pop_front();
      model_ovr = 1'b0;
    end
    check("read_data", 32'(read_data), 32'(last_rd));
    check_status("read");
  endtask

  initial begin
    int nrd;
    int r;
    logic [7:0] d;
    bit bp;
    logic sv;

    rst = 1'b0;
    rx  = 1'b1;
    ren = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_read_data", 32'(read_data), 32'h0);
    check("rst_rx_done", 32'(rx_done), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check_status("rst");

    // good frame then read
    frame_and_check(8'hA5, 1'b0, 1'b1);
    do_read();

    // parity error: dropped
    frame_and_check(8'h3C, 1'b1, 1'b1);

    // stop bit low then break for 3 bit times
    send_frame(8'h42, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * OS * tick_div) @(negedge clk);
    check_frame(8'h42, 1'b0, 1'b0);
    check("break_state", 32'(state_dbg), 32'(ST_BREAK));
    idle_gap();
    check("break_exit", 32'(state_dbg), 32'(ST_IDLE));
    frame_and_check(8'h11, 1'b0, 1'b1);
    do_read();

    // 4-tick glitch on idle line
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle_gap();
    idle_gap();
    check("glitch_done", 32'(done_q.size()), 32'd0);
    check("glitch_state", 32'(state_dbg), 32'(ST_IDLE));
    check_status("glitch");

    // overrun: 9 frames into depth 8, then drain
    for (int i = 1; i <= 9; i++) frame_and_check(8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) do_read();
    do_read();

    // reset mid-DATA with 3 words queued
    for (int i = 0; i < 3; i++) frame_and_check(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    exp_q.delete();
    model_ovr = 1'b0;
    last_rd   = 8'h00;
    check("midrst_read_data", 32'(read_data), 32'h0);
    check("midrst_rx_done", 32'(rx_done), 32'h0);
    check_status("midrst");
    idle_gap();
    idle_gap();
    check("midrst_no_done", 32'(done_q.size()), 32'd0);
    frame_and_check(8'h5A, 1'b0, 1'b1);
    do_read();

    // randomized frames, tick rates and reads
    for (int n = 0; n < 24; n++) begin
      tick_div = $urandom_range(1, 3);
      d  = 8'($urandom_range(0, 255));
      r  = $urandom_range(0, 99);
      bp = (r < 15);
      sv = (r >= 15 && r < 25) ? 1'b0 : 1'b1;
      frame_and_check(d, bp, sv);
      nrd = (n % 4 == 3) ? 0 : $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) do_read();
    end
    while (exp_q.size() > 0) do_read();
    do_read();

    check("stray_err_pulses", 32'(stray), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
